// File: rtl/image_link_pkg.sv
// rtl/image_link_pkg.sv - wire-format constants and types shared by image_receiver and image_sender
package image_link_pkg;

  localparam int          NUM_PIXELS  = 76800;
  localparam logic [11:0] START_PIXEL = 12'h00A;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {HUNT, RECV, DONE} frame_state_t;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchroniser, start-bit glitch rejection and stop-bit check
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state;
  logic [2:0]      sync;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            rx;
  logic            fall;

  // sync[2] is the previous synchronised sample, used only for edge detection
  assign rx   = sync[1];
  assign fall = sync[2] & ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], uart_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (fall) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF_BIT - 1)) begin
            cnt   <= '0;
            state <= rx ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/image_receiver.sv
// rtl/image_receiver.sv - pairs UART bytes into RGB444 pixels, hunts for the start marker and writes a frame to RAM
module image_receiver #(
  parameter int          CLK_FREQ       = 50_000_000,
  parameter int          BAUD_RATE      = 115200,
  parameter int          NUM_PIXELS     = image_link_pkg::NUM_PIXELS,
  parameter logic [11:0] START_PIXEL    = image_link_pkg::START_PIXEL,
  parameter int          TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_in,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  import image_link_pkg::*;

  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          frame_err;
  frame_state_t  state;
  logic          phase_low;
  logic [3:0]    hi_nib;
  logic [AW-1:0] count;
  logic [TW-1:0] idle_cnt;
  pixel_t        pixel;
  logic          nib_ok;
  logic          timeout_hit;
  logic          recv_abort;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_in    (uart_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign pixel       = {hi_nib, byte_data};
  assign nib_ok      = (byte_data[7:4] == 4'h0);
  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  // A byte arriving on the timeout cycle wins; a bad high byte mid-frame is fatal
  assign recv_abort  = frame_err || (byte_valid && !phase_low && !nib_ok) ||
                       (!byte_valid && timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      phase_low   <= 1'b0;
      hi_nib      <= '0;
      count       <= '0;
      idle_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        HUNT: begin
          if (frame_err) begin
            phase_low <= 1'b0;
          end else if (byte_valid) begin
            if (!phase_low) begin
              if (nib_ok) begin
                hi_nib    <= byte_data[3:0];
                phase_low <= 1'b1;
              end
            end else begin
              phase_low <= 1'b0;
              if (pixel == START_PIXEL) begin
                state    <= RECV;
                count    <= '0;
                idle_cnt <= '0;
                busy     <= 1'b1;
              end
            end
          end
        end
        RECV: begin
          if (recv_abort) begin
            frame_error <= 1'b1;
            busy        <= 1'b0;
            state       <= HUNT;
            phase_low   <= 1'b0;
          end else if (byte_valid) begin
            idle_cnt <= '0;
            if (!phase_low) begin
              hi_nib    <= byte_data[3:0];
              phase_low <= 1'b1;
            end else begin
              phase_low <= 1'b0;
              wr_en     <= 1'b1;
              wr_addr   <= 17'(count);
              wr_data   <= pixel;
              count     <= count + AW'(1);
              if (count == AW'(NUM_PIXELS - 1)) state <= DONE;
            end
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          phase_low  <= 1'b0;
          state      <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
